// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants, trap FSM encoding and helper functions for
//                the CPU trap controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  // Default trap vectors: exception entry, and interrupt line 0 entry
  localparam logic [31:0] EXC_VEC_DEFAULT  = 32'h8000_0008;
  localparam logic [31:0] IRQ_BASE_DEFAULT = 32'h8000_0010;

  // Trap controller state: normal execution or a handler running
  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_SERVICE = 1'b1
  } trap_state_e;

  // Cause field: one exception flag bit above the interrupt line index
  function automatic int cause_width(input int num_irq);
    return $clog2(num_irq) + 1;
  endfunction

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/prio_enc.sv
// ============================================================================
//  Module      : prio_enc
//  Description : Lowest-index-wins priority encoder. Reports whether any
//                request bit is set and the index of the lowest set bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_enc #(
  parameter int N = 8,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule : prio_enc

`default_nettype wire

// File: rtl/cpu_irq_ctrl.sv
// ============================================================================
//  Module      : cpu_irq_ctrl
//  Description : Trap controller beside the ID stage. Latches edge-triggered
//                interrupt requests, passes level requests through, applies
//                the mask, and replaces the ID instruction with a trap for
//                the illegal-instruction exception (highest priority) or the
//                lowest-numbered unmasked interrupt. Holds EPC and cause
//                until the handler executes its return instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_irq_ctrl
  import cpu_pkg::*;
#(
  parameter int                   NUM_IRQ   = 8,
  parameter int                   PC_W      = 32,
  parameter logic [NUM_IRQ-1:0]   EDGE_MASK = {NUM_IRQ{1'b1}},
  parameter logic [PC_W-1:0]      EXC_VEC   = PC_W'(EXC_VEC_DEFAULT),
  parameter logic [PC_W-1:0]      IRQ_BASE  = PC_W'(IRQ_BASE_DEFAULT)
) (
  input  logic                              clk,
  input  logic                              reset_b,
  input  logic [NUM_IRQ-1:0]                irq_in,
  input  logic                              mask_we,
  input  logic [NUM_IRQ-1:0]                mask_wdata,
  input  logic                              exc_req,
  input  logic                              id_valid,
  input  logic [PC_W-1:0]                   id_pc,
  input  logic                              eret,
  output logic                              trap_take,
  output logic [PC_W-1:0]                   trap_vector,
  output logic [PC_W-1:0]                   epc,
  output logic [cause_width(NUM_IRQ)-1:0]   cause,
  output logic                              in_service,
  output logic [NUM_IRQ-1:0]                irq_mask,
  output logic [NUM_IRQ-1:0]                pending,
  output logic                              double_fault
);

  localparam int IDX_W   = $clog2(NUM_IRQ);
  localparam int CAUSE_W = cause_width(NUM_IRQ);

  trap_state_e          state;
  trap_state_e          state_next;

  logic [NUM_IRQ-1:0]   irq_q;
  logic [NUM_IRQ-1:0]   pend;
  logic [NUM_IRQ-1:0]   pend_set;
  logic [NUM_IRQ-1:0]   pend_clr;
  logic [NUM_IRQ-1:0]   req;
  logic                 req_any;
  logic [IDX_W-1:0]     req_idx;
  logic [PC_W-1:0]      irq_vec;
  logic [CAUSE_W-1:0]   take_cause;
  logic                 take_irq;
  logic                 df_set;

  // Edge lines report the latched flag; level lines report the raw input.
  // pend never sets on level lines, so its level bits stay zero.
  assign pending    = (pend & EDGE_MASK) | (irq_in & ~EDGE_MASK);
  assign req        = pending & ~irq_mask;
  assign irq_vec    = IRQ_BASE + (PC_W'(req_idx) << 2);
  assign in_service = (state == ST_SERVICE);

  // A rising edge sets the flag; only a taken interrupt for that line clears
  // it. Set is OR-ed in last so a new edge survives a same-cycle clear.
  assign pend_set = irq_in & ~irq_q & EDGE_MASK;
  assign pend_clr = take_irq ? (NUM_IRQ'(1) << req_idx) : '0;

  prio_enc #(
    .N   (NUM_IRQ)
  ) u_prio_enc (
    .req (req),
    .any (req_any),
    .idx (req_idx)
  );

  // Next-state and trap decision; exception outranks any interrupt
  always_comb begin
    state_next  = state;
    trap_take   = 1'b0;
    trap_vector = EXC_VEC;
    take_cause  = '0;
    take_irq    = 1'b0;
    df_set      = 1'b0;
    case (state)
      ST_RUN: begin
        if (!exc_req && req_any) begin
          trap_vector = irq_vec;
        end
        if (id_valid && (exc_req || req_any)) begin
          trap_take  = 1'b1;
          state_next = ST_SERVICE;
          if (exc_req) begin
            take_cause = {1'b1, {IDX_W{1'b0}}};
          end else begin
            take_irq   = 1'b1;
            take_cause = {1'b0, req_idx};
          end
        end
      end
      ST_SERVICE: begin
        // No nesting: a fault inside a handler is only flagged
        if (id_valid && exc_req) begin
          df_set = 1'b1;
        end
        if (id_valid && eret) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Input history and latched edge requests
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      irq_q <= '0;
      pend  <= '0;
    end else begin
      irq_q <= irq_in;
      pend  <= (pend & ~pend_clr) | pend_set;
    end
  end

  // Mask register; a same-cycle take has already used the old value
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      irq_mask <= '1;
    end else if (mask_we) begin
      irq_mask <= mask_wdata;
    end
  end

  // Trap context: return PC and cause captured on every take
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      epc   <= '0;
      cause <= '0;
    end else if (trap_take) begin
      epc   <= id_pc;
      cause <= take_cause;
    end
  end

  // Sticky double-fault flag, cleared only by reset
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      double_fault <= 1'b0;
    end else if (df_set) begin
      double_fault <= 1'b1;
    end
  end

endmodule : cpu_irq_ctrl

`default_nettype wire

// File: tb/tb_cpu_irq_ctrl.sv
// ============================================================================
//  Module      : tb_cpu_irq_ctrl
//  Description : Directed, table-driven bench for cpu_irq_ctrl. One instance
//                uses edge-triggered lines, a second uses level lines.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_irq_ctrl;

  localparam logic [31:0] E = 32'h8000_0008;

  logic        clk;
  logic        reset_b;

  // Edge-triggered instance
  logic [7:0]  irq_in;
  logic        mask_we;
  logic [7:0]  mask_wdata;
  logic        exc_req;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        eret;
  logic        trap_take;
  logic [31:0] trap_vector;
  logic [31:0] epc;
  logic [3:0]  cause;
  logic        in_service;
  logic [7:0]  irq_mask;
  logic [7:0]  pending;
  logic        double_fault;

  // Level-triggered instance
  logic [7:0]  l_irq;
  logic        l_mask_we;
  logic [7:0]  l_mask_wdata;
  logic        l_exc;
  logic        l_idv;
  logic [31:0] l_pc;
  logic        l_eret;
  logic        l_take;
  logic [31:0] l_vec;
  logic [31:0] l_epc;
  logic [3:0]  l_cause;
  logic        l_insvc;
  logic [7:0]  l_mask;
  logic [7:0]  l_pending;
  logic        l_df;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]  irq;
    logic        mwe;
    logic [7:0]  mwd;
    logic        exc;
    logic        idv;
    logic        ert;
    logic [31:0] pc;
    logic        x_take;
    logic [31:0] x_vec;
    logic [31:0] x_epc;
    logic [3:0]  x_cause;
    logic        x_insvc;
    logic [7:0]  x_mask;
    logic [7:0]  x_pend;
    logic        x_df;
  } row_t;

  row_t tbl[25];

  cpu_irq_ctrl dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .irq_in       (irq_in),
    .mask_we      (mask_we),
    .mask_wdata   (mask_wdata),
    .exc_req      (exc_req),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .eret         (eret),
    .trap_take    (trap_take),
    .trap_vector  (trap_vector),
    .epc          (epc),
    .cause        (cause),
    .in_service   (in_service),
    .irq_mask     (irq_mask),
    .pending      (pending),
    .double_fault (double_fault)
  );

  cpu_irq_ctrl #(
    .EDGE_MASK (8'h00)
  ) dut_lvl (
    .clk          (clk),
    .reset_b      (reset_b),
    .irq_in       (l_irq),
    .mask_we      (l_mask_we),
    .mask_wdata   (l_mask_wdata),
    .exc_req      (l_exc),
    .id_valid     (l_idv),
    .id_pc        (l_pc),
    .eret         (l_eret),
    .trap_take    (l_take),
    .trap_vector  (l_vec),
    .epc          (l_epc),
    .cause        (l_cause),
    .in_service   (l_insvc),
    .irq_mask     (l_mask),
    .pending      (l_pending),
    .double_fault (l_df)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    // Columns: irq mwe mwd exc idv eret pc | take vec epc cause insvc mask pend df
    // Unmask all, single edge on line 3
    tbl[0]  = '{8'h00,1'b1,8'h00,1'b0,1'b0,1'b0,32'h000, 1'b0,E,            32'h000,4'h0,1'b0,8'hFF,8'h00,1'b0};
    tbl[1]  = '{8'h08,1'b0,8'h00,1'b0,1'b1,1'b0,32'h100, 1'b0,E,            32'h000,4'h0,1'b0,8'h00,8'h00,1'b0};
    tbl[2]  = '{8'h00,1'b0,8'h00,1'b0,1'b1,1'b0,32'h104, 1'b1,32'h8000_001C,32'h000,4'h0,1'b0,8'h00,8'h08,1'b0};
    // Lines 5 and 2 together: 2 first, 5 after the return
    tbl[3]  = '{8'h24,1'b0,8'h00,1'b0,1'b1,1'b0,32'h108, 1'b0,E,            32'h104,4'h3,1'b1,8'h00,8'h00,1'b0};
    tbl[4]  = '{8'h00,1'b0,8'h00,1'b0,1'b1,1'b1,32'h10C, 1'b0,E,            32'h104,4'h3,1'b1,8'h00,8'h24,1'b0};
    tbl[5]  = '{8'h00,1'b0,8'h00,1'b0,1'b1,1'b0,32'h110, 1'b1,32'h8000_0018,32'h104,4'h3,1'b0,8'h00,8'h24,1'b0};
    tbl[6]  = '{8'h00,1'b0,8'h00,1'b0,1'b1,1'b1,32'h114, 1'b0,E,            32'h110,4'h2,1'b1,8'h00,8'h20,1'b0};
    tbl[7]  = '{8'h00,1'b0,8'h00,1'b0,1'b1,1'b0,32'h118, 1'b1,32'h8000_0024,32'h110,4'h2,1'b0,8'h00,8'h20,1'b0};
    // Exception beats pending line 0; line 0 survives
    tbl[8]  = '{8'h01,1'b0,8'h00,1'b0,1'b1,1'b1,32'h11C, 1'b0,E,            32'h118,4'h5,1'b1,8'h00,8'h00,1'b0};
    tbl[9]  = '{8'h00,1'b0,8'h00,1'b1,1'b1,1'b0,32'h120, 1'b1,E,            32'h118,4'h5,1'b0,8'h00,8'h01,1'b0};
    tbl[10] = '{8'h00,1'b0,8'h00,1'b0,1'b1,1'b1,32'h124, 1'b0,E,            32'h120,4'h8,1'b1,8'h00,8'h01,1'b0};
    // Masked edge on line 1, unmask while stalled, then take
    tbl[11] = '{8'h00,1'b1,8'h03,1'b0,1'b0,1'b0,32'h000, 1'b0,E,            32'h120,4'h8,1'b0,8'h00,8'h01,1'b0};
    tbl[12] = '{8'h02,1'b0,8'h00,1'b0,1'b0,1'b0,32'h000, 1'b0,E,            32'h120,4'h8,1'b0,8'h03,8'h01,1'b0};
    tbl[13] = '{8'h00,1'b1,8'h01,1'b0,1'b0,1'b0,32'h000, 1'b0,E,            32'h120,4'h8,1'b0,8'h03,8'h03,1'b0};
    tbl[14] = '{8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,32'h000, 1'b0,E,            32'h120,4'h8,1'b0,8'h01,8'h03,1'b0};
    tbl[15] = '{8'h00,1'b0,8'h00,1'b0,1'b1,1'b0,32'h128, 1'b1,32'h8000_0014,32'h120,4'h8,1'b0,8'h01,8'h03,1'b0};
    // Edge on line 4 and a fault inside the handler
    tbl[16] = '{8'h10,1'b0,8'h00,1'b0,1'b1,1'b0,32'h12C, 1'b0,E,            32'h128,4'h1,1'b1,8'h01,8'h01,1'b0};
    tbl[17] = '{8'h00,1'b0,8'h00,1'b1,1'b1,1'b0,32'h130, 1'b0,E,            32'h128,4'h1,1'b1,8'h01,8'h11,1'b0};
    tbl[18] = '{8'h00,1'b0,8'h00,1'b0,1'b1,1'b1,32'h134, 1'b0,E,            32'h128,4'h1,1'b1,8'h01,8'h11,1'b1};
    tbl[19] = '{8'h00,1'b0,8'h00,1'b0,1'b1,1'b0,32'h138, 1'b1,32'h8000_0020,32'h128,4'h1,1'b0,8'h01,8'h11,1'b1};
    // Unmask in the same cycle as a possible take: old mask applies
    tbl[20] = '{8'h00,1'b0,8'h00,1'b0,1'b1,1'b1,32'h13C, 1'b0,E,            32'h138,4'h4,1'b1,8'h01,8'h01,1'b1};
    tbl[21] = '{8'h00,1'b1,8'h00,1'b0,1'b1,1'b0,32'h140, 1'b0,E,            32'h138,4'h4,1'b0,8'h01,8'h01,1'b1};
    // Take line 0 while a new edge arrives on it: set wins
    tbl[22] = '{8'h01,1'b0,8'h00,1'b0,1'b1,1'b0,32'h144, 1'b1,32'h8000_0010,32'h138,4'h4,1'b0,8'h00,8'h01,1'b1};
    tbl[23] = '{8'h81,1'b0,8'h00,1'b0,1'b0,1'b0,32'h000, 1'b0,E,            32'h144,4'h0,1'b1,8'h00,8'h01,1'b1};
    tbl[24] = '{8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,32'h000, 1'b0,E,            32'h144,4'h0,1'b1,8'h00,8'h81,1'b1};

    reset_b      = 1'b1;
    irq_in       = '0;
    mask_we      = 1'b0;
    mask_wdata   = '0;
    exc_req      = 1'b0;
    id_valid     = 1'b0;
    id_pc        = '0;
    eret         = 1'b0;
    l_irq        = '0;
    l_mask_we    = 1'b0;
    l_mask_wdata = '0;
    l_exc        = 1'b0;
    l_idv        = 1'b0;
    l_pc         = '0;
    l_eret       = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset trap_take",    32'(trap_take),    32'h0);
    chk("reset trap_vector",  trap_vector,       E);
    chk("reset epc",          epc,               32'h0);
    chk("reset cause",        32'(cause),        32'h0);
    chk("reset in_service",   32'(in_service),   32'h0);
    chk("reset irq_mask",     32'(irq_mask),     32'hFF);
    chk("reset pending",      32'(pending),      32'h0);
    chk("reset double_fault", 32'(double_fault), 32'h0);
    chk("reset lvl irq_mask", 32'(l_mask),       32'hFF);
    @(posedge clk);
    #1 reset_b = 1'b0;

    // Table: drive after the edge, compare on the falling edge
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      irq_in     = tbl[k].irq;
      mask_we    = tbl[k].mwe;
      mask_wdata = tbl[k].mwd;
      exc_req    = tbl[k].exc;
      id_valid   = tbl[k].idv;
      eret       = tbl[k].ert;
      id_pc      = tbl[k].pc;
      @(negedge clk);
      chk($sformatf("row%0d trap_take", k),    32'(trap_take),    32'(tbl[k].x_take));
      if (tbl[k].x_take || tbl[k].x_insvc)
        chk($sformatf("row%0d trap_vector", k), trap_vector,     tbl[k].x_vec);
      chk($sformatf("row%0d epc", k),          epc,               tbl[k].x_epc);
      chk($sformatf("row%0d cause", k),        32'(cause),        32'(tbl[k].x_cause));
      chk($sformatf("row%0d in_service", k),   32'(in_service),   32'(tbl[k].x_insvc));
      chk($sformatf("row%0d irq_mask", k),     32'(irq_mask),     32'(tbl[k].x_mask));
      chk($sformatf("row%0d pending", k),      32'(pending),      32'(tbl[k].x_pend));
      chk($sformatf("row%0d double_fault", k), 32'(double_fault), 32'(tbl[k].x_df));
    end

    // Asynchronous reset mid-service with pend = 8'h81
    #2 reset_b = 1'b1;
    #1;
    chk("midrst trap_take",    32'(trap_take),    32'h0);
    chk("midrst trap_vector",  trap_vector,       E);
    chk("midrst epc",          epc,               32'h0);
    chk("midrst cause",        32'(cause),        32'h0);
    chk("midrst in_service",   32'(in_service),   32'h0);
    chk("midrst irq_mask",     32'(irq_mask),     32'hFF);
    chk("midrst pending",      32'(pending),      32'h0);
    chk("midrst double_fault", 32'(double_fault), 32'h0);
    @(posedge clk);
    #1 reset_b = 1'b0;
    @(negedge clk);
    chk("postrst pending",    32'(pending),    32'h0);
    chk("postrst in_service", 32'(in_service), 32'h0);

    // Level line 6: take in the very cycle the input rises
    @(posedge clk);
    #1;
    l_mask_we    = 1'b1;
    l_mask_wdata = 8'h00;
    @(posedge clk);
    #1;
    l_mask_we = 1'b0;
    l_irq     = 8'h40;
    l_idv     = 1'b1;
    l_pc      = 32'h200;
    #1;
    chk("lvl trap_take",   32'(l_take),    32'h1);
    chk("lvl trap_vector", l_vec,          32'h8000_0028);
    chk("lvl pending",     32'(l_pending), 32'h40);
    @(posedge clk);
    #1;
    l_irq = 8'h00;
    l_idv = 1'b0;
    @(negedge clk);
    chk("lvl in_service", 32'(l_insvc),   32'h1);
    chk("lvl cause",      32'(l_cause),   32'h6);
    chk("lvl epc",        l_epc,          32'h200);
    chk("lvl pending off", 32'(l_pending), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cpu_irq_ctrl

`default_nettype wire
